// File: rtl/riscv_pkg.sv
// Shared RV32 decode constants and the ID/EX pipeline record used by the decode stage.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  typedef struct packed {
    logic        reg_write;
    logic [1:0]  result_src;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic [2:0]  alu_control;
    logic        alu_src;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm_ext;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
  } idex_t;

endpackage

// File: rtl/register_file.sv
// 32x32 register file: x0 hard-wired to zero, write-through bypass on both read ports.
module register_file
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [4:0]  A3,
  input  logic [31:0] WD3,
  input  logic        WE3,
  output logic [31:0] RD1,
  output logic [31:0] RD2
);

  logic [31:0][31:0] regs_q;
  logic [31:0][31:0] regs_d;
  logic              wr_en;

  assign wr_en = WE3 && (A3 != 5'd0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[A3] = WD3;
  end

  // Reset has priority, so a writeback in the same cycle as rst is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) regs_q <= '0;
    else     regs_q <= regs_d;
  end

  assign RD1 = (A1 == 5'd0)              ? 32'd0 :
               (wr_en && (A3 == A1))     ? WD3   : regs_q[A1];
  assign RD2 = (A2 == 5'd0)              ? 32'd0 :
               (wr_en && (A3 == A2))     ? WD3   : regs_q[A2];

endmodule

// File: rtl/decode_cycle.sv
// RV32 decode stage: main/ALU decoder, immediate extension, register read and ID/EX register.
module decode_cycle
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] InstrD,
  input  logic [31:0] PCD,
  input  logic [31:0] PCPlus4D,
  input  logic        RegWriteW,
  input  logic [4:0]  RdW,
  input  logic [31:0] ResultW,
  input  logic        FlushE,
  output logic        RegWriteE,
  output logic [1:0]  ResultSrcE,
  output logic        MemWriteE,
  output logic        JumpE,
  output logic        BranchE,
  output logic [2:0]  ALUControlE,
  output logic        ALUSrcE,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E,
  output logic [31:0] ImmExtE,
  output logic [31:0] PCE,
  output logic [31:0] PCPlus4E,
  output logic [4:0]  Rs1E,
  output logic [4:0]  Rs2E,
  output logic [4:0]  RdE,
  output logic [2:0]  Funct3E
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic [4:0]  rs1, rs2, rd;
  logic        reg_write, alu_src, mem_write, branch, jump;
  logic [1:0]  imm_src, result_src, alu_op;
  logic [2:0]  alu_control;
  logic [31:0] imm_ext, rd1, rd2;
  idex_t       idex_d, idex_q;

  assign opcode   = InstrD[6:0];
  assign rd       = InstrD[11:7];
  assign funct3   = InstrD[14:12];
  assign rs1      = InstrD[19:15];
  assign rs2      = InstrD[24:20];
  assign funct7b5 = InstrD[30];

  // Unlisted opcodes fall through with every control bit low, i.e. a bubble.
  always_comb begin
    reg_write  = 1'b0;
    imm_src    = IMM_I;
    alu_src    = 1'b0;
    mem_write  = 1'b0;
    result_src = RES_ALU;
    branch     = 1'b0;
    alu_op     = ALUOP_ADD;
    jump       = 1'b0;
    case (opcode)
      OP_LOAD:   begin reg_write = 1'b1; alu_src = 1'b1; result_src = RES_MEM; end
      OP_STORE:  begin imm_src = IMM_S; alu_src = 1'b1; mem_write = 1'b1; end
      OP_RTYPE:  begin reg_write = 1'b1; alu_op = ALUOP_FUNC; end
      OP_ITYPE:  begin reg_write = 1'b1; alu_src = 1'b1; alu_op = ALUOP_FUNC; end
      OP_BRANCH: begin imm_src = IMM_B; branch = 1'b1; alu_op = ALUOP_SUB; end
      OP_JAL:    begin reg_write = 1'b1; imm_src = IMM_J; result_src = RES_PC4; jump = 1'b1; end
      default:   ;
    endcase
  end

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      default: begin
        case (funct3)
          3'b000:  alu_control = (opcode[5] && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control = ALU_SLL;
          3'b010:  alu_control = ALU_SLT;
          3'b100:  alu_control = ALU_XOR;
          3'b101:  alu_control = ALU_SRL;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
    endcase
  end

  always_comb begin
    imm_ext = '0;
    case (imm_src)
      IMM_I: imm_ext = {{20{InstrD[31]}}, InstrD[31:20]};
      IMM_S: imm_ext = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      IMM_B: imm_ext = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
      IMM_J: imm_ext = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
      default: imm_ext = '0;
    endcase
  end

  register_file u_register_file (
    .clk (clk),
    .rst (rst),
    .A1  (rs1),
    .A2  (rs2),
    .A3  (RdW),
    .WD3 (ResultW),
    .WE3 (RegWriteW),
    .RD1 (rd1),
    .RD2 (rd2)
  );

  always_comb begin
    idex_d = '0;
    if (!FlushE) begin
      idex_d.reg_write   = reg_write;
      idex_d.result_src  = result_src;
      idex_d.mem_write   = mem_write;
      idex_d.jump        = jump;
      idex_d.branch      = branch;
      idex_d.alu_control = alu_control;
      idex_d.alu_src     = alu_src;
      idex_d.rd1         = rd1;
      idex_d.rd2         = rd2;
      idex_d.imm_ext     = imm_ext;
      idex_d.pc          = PCD;
      idex_d.pc_plus4    = PCPlus4D;
      idex_d.rs1         = rs1;
      idex_d.rs2         = rs2;
      idex_d.rd          = rd;
      idex_d.funct3      = funct3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) idex_q <= '0;
    else     idex_q <= idex_d;
  end

  assign RegWriteE   = idex_q.reg_write;
  assign ResultSrcE  = idex_q.result_src;
  assign MemWriteE   = idex_q.mem_write;
  assign JumpE       = idex_q.jump;
  assign BranchE     = idex_q.branch;
  assign ALUControlE = idex_q.alu_control;
  assign ALUSrcE     = idex_q.alu_src;
  assign RD1E        = idex_q.rd1;
  assign RD2E        = idex_q.rd2;
  assign ImmExtE     = idex_q.imm_ext;
  assign PCE         = idex_q.pc;
  assign PCPlus4E    = idex_q.pc_plus4;
  assign Rs1E        = idex_q.rs1;
  assign Rs2E        = idex_q.rs2;
  assign RdE         = idex_q.rd;
  assign Funct3E     = idex_q.funct3;

endmodule

// File: tb/tb_decode_cycle.sv
// Directed bench for decode_cycle: opcode/ALU decode table plus reset, writeback, bypass and flush sequences.
module tb_decode_cycle;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] InstrD = '0, PCD = '0, PCPlus4D = '0;
  logic        RegWriteW = 1'b0;
  logic [4:0]  RdW = '0;
  logic [31:0] ResultW = '0;
  logic        FlushE = 1'b0;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE, Funct3E;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic [187:0] all_e;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  decode_cycle dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW), .FlushE(FlushE),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .BranchE(BranchE), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .Funct3E(Funct3E)
  );

  assign all_e = {RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE, ALUSrcE,
                  RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE, Funct3E};

  typedef struct {
    logic [31:0] instr;
    logic        rw;
    logic [1:0]  rsrc;
    logic        mw;
    logic        j;
    logic        b;
    logic [2:0]  alu;
    logic        asrc;
    logic        chk_imm;
    logic [31:0] imm;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [187:0] act, input logic [187:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic flush,
                       input logic we, input logic [4:0] rdw, input logic [31:0] res);
    InstrD = instr; FlushE = flush; RegWriteW = we; RdW = rdw; ResultW = res;
  endtask

  initial begin
    // instr, RegWrite, ResultSrc, MemWrite, Jump, Branch, ALUControl, ALUSrc, chk_imm, imm
    vecs.push_back(vec_t'{32'h002081B3, 1, 2'b00, 0, 0, 0, 3'b000, 0, 0, 32'h0});        // add
    vecs.push_back(vec_t'{32'h402081B3, 1, 2'b00, 0, 0, 0, 3'b001, 0, 0, 32'h0});        // sub
    vecs.push_back(vec_t'{32'h0020F1B3, 1, 2'b00, 0, 0, 0, 3'b010, 0, 0, 32'h0});        // and
    vecs.push_back(vec_t'{32'h0020E1B3, 1, 2'b00, 0, 0, 0, 3'b011, 0, 0, 32'h0});        // or
    vecs.push_back(vec_t'{32'h0020C1B3, 1, 2'b00, 0, 0, 0, 3'b100, 0, 0, 32'h0});        // xor
    vecs.push_back(vec_t'{32'h0020A1B3, 1, 2'b00, 0, 0, 0, 3'b101, 0, 0, 32'h0});        // slt
    vecs.push_back(vec_t'{32'h002091B3, 1, 2'b00, 0, 0, 0, 3'b110, 0, 0, 32'h0});        // sll
    vecs.push_back(vec_t'{32'h0020D1B3, 1, 2'b00, 0, 0, 0, 3'b111, 0, 0, 32'h0});        // srl
    vecs.push_back(vec_t'{32'h0020B1B3, 1, 2'b00, 0, 0, 0, 3'b000, 0, 0, 32'h0});        // f3=011 -> add
    vecs.push_back(vec_t'{32'hFFF28313, 1, 2'b00, 0, 0, 0, 3'b000, 1, 1, 32'hFFFFFFFF}); // addi -1
    vecs.push_back(vec_t'{32'h40028313, 1, 2'b00, 0, 0, 0, 3'b000, 1, 1, 32'h00000400}); // addi, bit30 set
    vecs.push_back(vec_t'{32'h0FF2C313, 1, 2'b00, 0, 0, 0, 3'b100, 1, 1, 32'h000000FF}); // xori
    vecs.push_back(vec_t'{32'hFFC2A303, 1, 2'b01, 0, 0, 0, 3'b000, 1, 1, 32'hFFFFFFFC}); // lw -4
    vecs.push_back(vec_t'{32'hFE20AC23, 0, 2'b00, 1, 0, 0, 3'b000, 1, 1, 32'hFFFFFFF8}); // sw -8
    vecs.push_back(vec_t'{32'h00209863, 0, 2'b00, 0, 0, 1, 3'b001, 0, 1, 32'h00000010}); // bne +16
    vecs.push_back(vec_t'{32'h001000EF, 1, 2'b10, 0, 1, 0, 3'b000, 0, 1, 32'h00000800}); // jal +2048
    vecs.push_back(vec_t'{32'hFFDFF0EF, 1, 2'b10, 0, 1, 0, 3'b000, 0, 1, 32'hFFFFFFFC}); // jal -4
    vecs.push_back(vec_t'{32'h123452B7, 0, 2'b00, 0, 0, 0, 3'b000, 0, 0, 32'h0});        // lui: bubble
    vecs.push_back(vec_t'{32'h00000000, 0, 2'b00, 0, 0, 0, 3'b000, 0, 0, 32'h0});        // illegal

    // Reset with a live instruction on the inputs.
    drive(32'h00128313, 1'b0, 1'b0, 5'd0, 32'h0);
    #2;
    chk("reset_outputs", all_e, '0);
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    chk("post_reset_rd1", RD1E, 32'h0);
    chk("post_reset_rd", RdE, 5'd6);

    // Write x5 then addi x6,x5,1.
    drive(32'h00000000, 1'b0, 1'b1, 5'd5, 32'h00001234);
    cycle();
    drive(32'h00128313, 1'b0, 1'b0, 5'd0, 32'h0);
    PCD = 32'h00000100; PCPlus4D = 32'h00000104;
    cycle();
    chk("addi_rd1", RD1E, 32'h00001234);
    chk("addi_imm", ImmExtE, 32'h1);
    chk("addi_rd", RdE, 5'd6);
    chk("addi_rs1", Rs1E, 5'd5);
    chk("addi_rs2", Rs2E, 5'd1);
    chk("addi_f3", Funct3E, 3'b000);
    chk("addi_ctrl", {RegWriteE, ALUSrcE, ALUControlE, MemWriteE, ResultSrcE}, {1'b1, 1'b1, 3'b000, 1'b0, 2'b00});
    chk("addi_pc", PCE, 32'h00000100);
    chk("addi_pc4", PCPlus4E, 32'h00000104);

    // Writes to x0 never land and never bypass.
    drive(32'h00000093, 1'b0, 1'b1, 5'd0, 32'hDEADBEEF);
    cycle();
    chk("x0_same_cycle", RD1E, 32'h0);
    drive(32'h00000093, 1'b0, 1'b0, 5'd0, 32'h0);
    cycle();
    chk("x0_after_write", RD1E, 32'h0);

    // Same-cycle bypass, then the stored value.
    drive(32'h00038093, 1'b0, 1'b1, 5'd7, 32'hCAFEF00D);
    cycle();
    chk("bypass_rd1", RD1E, 32'hCAFEF00D);
    drive(32'h00038093, 1'b0, 1'b0, 5'd0, 32'h0);
    cycle();
    chk("stored_x7", RD1E, 32'hCAFEF00D);
    drive(32'h00700133, 1'b0, 1'b1, 5'd7, 32'h0BADF00D); // add x2,x0,x7: bypass on port 2
    cycle();
    chk("bypass_rd2", RD2E, 32'h0BADF00D);

    // beq x1,x2,-8
    drive(32'hFE208CE3, 1'b0, 1'b0, 5'd0, 32'h0);
    cycle();
    chk("beq_imm", ImmExtE, 32'hFFFFFFF8);
    chk("beq_ctrl", {BranchE, ALUControlE, RegWriteE, MemWriteE, JumpE}, {1'b1, 3'b001, 1'b0, 1'b0, 1'b0});

    // sw x2,4(x1), unflushed then flushed while x9 is written back.
    drive(32'h0020A223, 1'b0, 1'b0, 5'd0, 32'h0);
    cycle();
    chk("sw_memwrite", MemWriteE, 1'b1);
    chk("sw_imm", ImmExtE, 32'h4);
    drive(32'h0020A223, 1'b1, 1'b1, 5'd9, 32'h00000055);
    cycle();
    chk("flush_memwrite", MemWriteE, 1'b0);
    chk("flush_all_zero", all_e, '0);
    drive(32'h00048093, 1'b0, 1'b0, 5'd0, 32'h0); // addi x1,x9,0
    cycle();
    chk("flush_write_kept", RD1E, 32'h00000055);

    // Decode table.
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].instr, 1'b0, 1'b0, 5'd0, 32'h0);
      cycle();
      chk($sformatf("v%0d_regwrite", i), RegWriteE, vecs[i].rw);
      chk($sformatf("v%0d_resultsrc", i), ResultSrcE, vecs[i].rsrc);
      chk($sformatf("v%0d_memwrite", i), MemWriteE, vecs[i].mw);
      chk($sformatf("v%0d_jump", i), JumpE, vecs[i].j);
      chk($sformatf("v%0d_branch", i), BranchE, vecs[i].b);
      chk($sformatf("v%0d_aluctrl", i), ALUControlE, vecs[i].alu);
      chk($sformatf("v%0d_alusrc", i), ALUSrcE, vecs[i].asrc);
      if (vecs[i].chk_imm) chk($sformatf("v%0d_imm", i), ImmExtE, vecs[i].imm);
    end

    // Mid-cycle reset with a pending writeback to x5.
    drive(32'h00028093, 1'b0, 1'b1, 5'd5, 32'h77777777);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_reset_outputs", all_e, '0);
    cycle();
    @(negedge clk);
    rst = 1'b0;
    drive(32'h00038093, 1'b0, 1'b0, 5'd0, 32'h0);
    cycle();
    chk("reset_cleared_x7", RD1E, 32'h0);
    drive(32'h00028093, 1'b0, 1'b0, 5'd0, 32'h0);
    cycle();
    chk("reset_dropped_wb_x5", RD1E, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/decode_cycle.md
DECODE_CYCLE -- requirements
Module: decode_cycle

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous reset, active-high.
REQ-003 SHALL have inputs InstrD[31:0], PCD[31:0] and PCPlus4D[31:0]: IF/ID register contents from the fetch stage.
REQ-004 SHALL have writeback inputs RegWriteW (1), RdW[4:0] and ResultW[31:0].
REQ-005 SHALL have input FlushE, 1 bit: bubble the ID/EX register on the next edge.
REQ-006 SHALL have control outputs RegWriteE (1), ResultSrcE[1:0], MemWriteE (1), JumpE (1), BranchE (1), ALUControlE[2:0] and ALUSrcE (1).
REQ-007 SHALL have data outputs RD1E, RD2E, ImmExtE, PCE and PCPlus4E (32 bits each); Rs1E, Rs2E and RdE (5 bits each); Funct3E (3 bits).

Function
REQ-008 SHALL register all outputs in one ID/EX register with 1-cycle latency: InstrD present at edge N appears decoded on the E outputs after edge N.
REQ-009 SHALL take fields from InstrD as follows: rs1=[19:15], rs2=[24:20], rd=[11:7], funct3=[14:12], funct7b5=[30], opcode=[6:0].
REQ-010 SHALL decode opcodes as {RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp, Jump}:
- lw 0000011: 1, 00, 1, 0, 01, 0, 00, 0
- sw 0100011: 0, 01, 1, 1, xx->00, 0, 00, 0
- R 0110011: 1, xx, 0, 0, 00, 0, 10, 0
- I-ALU 0010011: 1, 00, 1, 0, 00, 0, 10, 0
- branch 1100011: 0, 10, 0, 0, 00, 1, 01, 0
- jal 1101111: 1, 11, x, 0, 10, 0, 00, 1
REQ-011 SHALL treat any other opcode as a bubble: RegWrite, MemWrite, Branch and Jump all 0.
REQ-012 SHALL encode ALUControl as 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl.
REQ-013 SHALL derive ALUControl from ALUOp and funct3 as follows:
- ALUOp 00 -> add.
- ALUOp 01 -> sub.
- ALUOp 10, funct3 000 -> sub only when opcode[5] & funct7b5, otherwise add.
- ALUOp 10, other funct3: 001 sll, 010 slt, 100 xor, 101 srl, 110 or, 111 and.
- ALUOp 10, funct3 011 -> add.
REQ-014 SHALL sign-extend immediates from InstrD[31] to 32 bits:
- I: [31:20]
- S: {[31:25], [11:7]}
- B: {[31], [7], [30:25], [11:8], 0}
- J: {[31], [19:12], [20], [30:21], 0}
REQ-015 SHALL provide a 32x32 register file with two combinational read ports and one write port; the write occurs at the rising edge when RegWriteW=1 and RdW!=0.
REQ-016 SHALL return 0 for every read of x0; writes to x0 are discarded.
REQ-017 SHALL bypass same-cycle writes: when RegWriteW=1, RdW!=0 and RdW equals rs1 (or rs2), the read port returns ResultW.
REQ-018 SHALL, at an edge where FlushE=1, load all ID/EX fields with 0, overriding InstrD decode; the regfile write in the same cycle still occurs.
REQ-019 SHALL pass PCD, PCPlus4D, rs1, rs2, rd and funct3 through unmodified when not flushed.

Reset
REQ-020 SHALL, while rst=1, asynchronously drive every output to 0 and clear all 32 registers to 0.
REQ-021 SHALL apply rst asserted mid-operation immediately and discard any same-cycle writeback.

Structure
REQ-022 SHALL take opcode constants, ALUControl codes, ImmSrc codes (I 00, S 01, B 10, J 11) and ResultSrc codes (ALU 00, mem 01, PC+4 10) from shared package riscv_pkg.
REQ-023 SHALL implement the register file as sub-module register_file (clk, rst, A1, A2, A3, WD3, WE3, RD1, RD2); decoder and immediate logic stay inline.

Verification
REQ-024 Reset: assert rst with InstrD=0x00128313 -> all outputs 0; after release, RD1E reads 0 for any rs.
REQ-025 Write then addi: write x5=0x00001234 via W port, then InstrD=0x00128313 (addi x6,x5,1) -> next cycle RD1E=0x00001234, ImmExtE=1, RdE=6, RegWriteE=1, ALUSrcE=1, ALUControlE=000.
REQ-026 x0 and bypass:
- RegWriteW=1, RdW=0, ResultW=0xDEADBEEF -> subsequent read of x0 gives 0.
- Same-cycle RdW=7, ResultW=0xCAFEF00D with InstrD reading rs1=7 -> RD1E=0xCAFEF00D.
REQ-027 Branch: InstrD=0xFE208CE3 (beq x1,x2,-8) -> ImmExtE=0xFFFFFFF8, BranchE=1, ALUControlE=001, RegWriteE=0, MemWriteE=0.
REQ-028 Flush: InstrD=sw with FlushE=1 -> MemWriteE=0 and all E outputs 0 next cycle.
REQ-029 Illegal opcode: InstrD=0x00000000 -> RegWriteE=0, MemWriteE=0, BranchE=0, JumpE=0.
